// File: rtl/bullet_motion.sv
// Single-bullet motion engine: spawns from the tank on fire, takes SPEED 1-pixel sub-steps
// per frame, reflects off screen edges and collisions, retires on lifetime or bounce limit.
module bullet_motion #(
  parameter int SPEED       = 2,
  parameter int LIFETIME    = 300,
  parameter int MAX_BOUNCES = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] TankDir,
  input  logic       collisionX,
  input  logic       collisionY,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       bullet_active,
  output logic       despawn
);

  localparam int LW = ($clog2(LIFETIME + 1) > 9) ? $clog2(LIFETIME + 1) : 9;
  localparam int BW = ($clog2(MAX_BOUNCES + 2) > 1) ? $clog2(MAX_BOUNCES + 2) : 1;
  localparam int SW = ($clog2(SPEED + 1) > 1) ? $clog2(SPEED + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

  state_t          r_state, w_state_nxt;
  logic [9:0]      r_x, r_y, w_x_nxt, w_y_nxt;
  // Velocities are two's complement: 2'b01 = +1, 2'b11 = -1, 2'b00 = still.
  logic [1:0]      r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic [LW-1:0]   r_life, w_life_nxt;
  logic [BW-1:0]   r_bounces, w_bounces_nxt;
  logic [SW-1:0]   r_sub, w_sub_nxt;
  logic            r_despawn, w_despawn_nxt;
  logic            w_refl_x, w_refl_y, w_refl;

  assign w_refl_x = (r_dx != 2'b00) &&
                    (collisionX || (r_x == 10'd0   && r_dx == 2'b11)
                                || (r_x == 10'd639 && r_dx == 2'b01));
  assign w_refl_y = (r_dy != 2'b00) &&
                    (collisionY || (r_y == 10'd0   && r_dy == 2'b11)
                                || (r_y == 10'd479 && r_dy == 2'b01));
  assign w_refl   = w_refl_x || w_refl_y;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_life    <= '0;
      r_bounces <= '0;
      r_sub     <= '0;
      r_despawn <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_dx      <= w_dx_nxt;
      r_dy      <= w_dy_nxt;
      r_life    <= w_life_nxt;
      r_bounces <= w_bounces_nxt;
      r_sub     <= w_sub_nxt;
      r_despawn <= w_despawn_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_dx_nxt      = r_dx;
    w_dy_nxt      = r_dy;
    w_life_nxt    = r_life;
    w_bounces_nxt = r_bounces;
    w_sub_nxt     = r_sub;
    w_despawn_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fire) begin
          w_state_nxt   = S_WAIT;
          w_x_nxt       = TankX;
          w_y_nxt       = TankY;
          w_life_nxt    = LW'(LIFETIME);
          w_bounces_nxt = '0;
          w_dx_nxt      = 2'b00;
          w_dy_nxt      = 2'b00;
          case (TankDir)
            2'd0:    w_dy_nxt = 2'b11;
            2'd1:    w_dx_nxt = 2'b01;
            2'd2:    w_dy_nxt = 2'b01;
            default: w_dx_nxt = 2'b11;
          endcase
        end
      end
      S_WAIT: begin
        if (frame_tick) begin
          if (r_life <= LW'(1)) begin
            w_life_nxt    = '0;
            w_state_nxt   = S_IDLE;
            w_despawn_nxt = 1'b1;
          end else begin
            w_life_nxt  = r_life - LW'(1);
            w_sub_nxt   = SW'(SPEED);
            w_state_nxt = S_STEP;
          end
        end
      end
      S_STEP: begin
        // A reflection past the bounce budget retires the bullet where it stands.
        if (w_refl && r_bounces >= BW'(MAX_BOUNCES)) begin
          w_state_nxt   = S_IDLE;
          w_despawn_nxt = 1'b1;
        end else begin
          if (w_refl_x) w_dx_nxt = 2'b00 - r_dx;
          else          w_x_nxt  = r_x + {{8{r_dx[1]}}, r_dx};
          if (w_refl_y) w_dy_nxt = 2'b00 - r_dy;
          else          w_y_nxt  = r_y + {{8{r_dy[1]}}, r_dy};
          if (w_refl)   w_bounces_nxt = r_bounces + BW'(1);
          w_sub_nxt = r_sub - SW'(1);
          if (r_sub <= SW'(1)) w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign BulletX       = r_x;
  assign BulletY       = r_y;
  assign bullet_active = (r_state != S_IDLE);
  assign despawn       = r_despawn;

endmodule

// File: tb/tb_bullet_motion.sv
// Randomized bench for bullet_motion: a frame/step-level bullet model checked every cycle,
// plus directed sequences with hand-computed positions for spawn, edge bounce, bounce limit, lifetime and reset.
module tb_bullet_motion;
  localparam int SPEED = 2;
  localparam int LIFE  = 300;
  localparam int MAXB  = 5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] TankX = '0;
  logic [9:0] TankY = '0;
  logic [1:0] TankDir = '0;
  logic       collisionX = 1'b0;
  logic       collisionY = 1'b0;
  logic [9:0] BulletX, BulletY, s_x, s_y;
  logic       bullet_active, despawn, s_active, s_desp;

  int n_checks = 0;
  int n_errors = 0;

  bullet_motion #(.SPEED(SPEED), .LIFETIME(LIFE), .MAX_BOUNCES(MAXB)) u_dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire),
    .TankX(TankX), .TankY(TankY), .TankDir(TankDir),
    .collisionX(collisionX), .collisionY(collisionY),
    .BulletX(BulletX), .BulletY(BulletY), .bullet_active(bullet_active), .despawn(despawn)
  );

  bullet_motion #(.SPEED(SPEED), .LIFETIME(3), .MAX_BOUNCES(MAXB)) u_short (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire),
    .TankX(TankX), .TankY(TankY), .TankDir(TankDir),
    .collisionX(collisionX), .collisionY(collisionY),
    .BulletX(s_x), .BulletY(s_y), .bullet_active(s_active), .despawn(s_desp)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference bullet: alive flag, frames of life left, sub-steps still owed this frame.
  bit m_valid = 0, m_alive = 0, m_desp = 0;
  int m_x = 0, m_y = 0, m_vx = 0, m_vy = 0, m_life = 0, m_bounces = 0, m_steps = 0;

  task automatic model_step();
    bit hx, hy;
    m_desp = 0;
    if (Reset) begin
      m_valid = 1; m_alive = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0;
      m_life = 0; m_bounces = 0; m_steps = 0;
    end else if (!m_alive) begin
      if (fire) begin
        m_alive = 1; m_x = int'(TankX); m_y = int'(TankY);
        m_vx = (TankDir == 2'd1) ? 1 : (TankDir == 2'd3) ? -1 : 0;
        m_vy = (TankDir == 2'd2) ? 1 : (TankDir == 2'd0) ? -1 : 0;
        m_life = LIFE; m_bounces = 0; m_steps = 0;
      end
    end else if (m_steps == 0) begin
      if (frame_tick) begin
        m_life = m_life - 1;
        if (m_life == 0) begin m_alive = 0; m_desp = 1; end
        else m_steps = SPEED;
      end
    end else begin
      hx = (m_vx != 0) && (collisionX || (m_x == 0 && m_vx < 0) || (m_x == 639 && m_vx > 0));
      hy = (m_vy != 0) && (collisionY || (m_y == 0 && m_vy < 0) || (m_y == 479 && m_vy > 0));
      if ((hx || hy) && m_bounces == MAXB) begin
        m_alive = 0; m_desp = 1;
      end else begin
        if (hx) m_vx = -m_vx; else m_x = (m_x + m_vx) & 1023;
        if (hy) m_vy = -m_vy; else m_y = (m_y + m_vy) & 1023;
        if (hx || hy) m_bounces++;
        m_steps--;
      end
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    @(negedge Clk);
    if (m_valid) begin
      check("model_x", int'(BulletX), m_x);
      check("model_y", int'(BulletY), m_y);
      check("model_active", int'(bullet_active), int'(m_alive));
      check("model_despawn", int'(despawn), int'(m_desp));
    end
  end

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic frame(); // one tick followed by the SPEED sub-step cycles
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (SPEED) step();
  endtask

  initial begin
    step();
    check("rst_x", int'(BulletX), 0);
    check("rst_active", int'(bullet_active), 0);
    check("rst_despawn", int'(despawn), 0);

    // Spawn heading right, two frames of motion, short-lived twin expires on third tick
    Reset = 1'b0; fire = 1'b1; TankX = 10'd100; TankY = 10'd50; TankDir = 2'd1;
    step(); fire = 1'b0;
    check("spawn_active", int'(bullet_active), 1);
    check("spawn_x", int'(BulletX), 100);
    check("spawn_y", int'(BulletY), 50);
    frame();
    check("frame1_x", int'(BulletX), 102);
    check("frame1_y", int'(BulletY), 50);
    frame();
    check("short_frame2_x", int'(s_x), 104);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("short_despawn", int'(s_desp), 1);
    check("short_active", int'(s_active), 0);
    check("short_final_x", int'(s_x), 104);
    check("long_still_active", int'(bullet_active), 1);
    step();
    check("short_despawn_pulse", int'(s_desp), 0);

    // Reset while mid-STEP, then spawn heading left at X=1
    Reset = 1'b1; step(); Reset = 1'b0;
    check("midrst_x", int'(BulletX), 0);
    check("midrst_y", int'(BulletY), 0);
    check("midrst_active", int'(bullet_active), 0);
    fire = 1'b1; TankX = 10'd1; TankY = 10'd200; TankDir = 2'd3;
    step(); fire = 1'b0;
    check("left_spawn_x", int'(BulletX), 1);
    check("left_spawn_active", int'(bullet_active), 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); check("left_sub1_x", int'(BulletX), 0);
    step(); check("left_bounce_x", int'(BulletX), 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); check("left_after_bounce_x", int'(BulletX), 1);
    step(); check("left_after_bounce_x2", int'(BulletX), 2);

    // Held collision: every sub-step reflects; fire held throughout must not respawn
    Reset = 1'b1; step(); Reset = 1'b0;
    fire = 1'b1; TankX = 10'd300; TankY = 10'd100; TankDir = 2'd1; collisionX = 1'b1;
    step();
    check("coll_spawn_x", int'(BulletX), 300);
    TankX = 10'd7;
    frame(); frame();
    check("coll_x_after_4", int'(BulletX), 300);
    check("coll_active_after_4", int'(bullet_active), 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    check("coll_5th_active", int'(bullet_active), 1);
    check("coll_5th_despawn", int'(despawn), 0);
    step();
    check("coll_6th_despawn", int'(despawn), 1);
    check("coll_6th_active", int'(bullet_active), 0);
    check("coll_6th_x", int'(BulletX), 300);
    step();
    check("respawn_active", int'(bullet_active), 1);
    check("respawn_x", int'(BulletX), 7);
    check("respawn_despawn", int'(despawn), 0);
    fire = 1'b0; collisionX = 1'b0;
    Reset = 1'b1; step(); Reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      fire       = ($urandom_range(0, 3) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      TankX      = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 639))
                 : ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 4))
                                               : 10'($urandom_range(635, 639));
      TankY      = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 479))
                 : ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 4))
                                               : 10'($urandom_range(475, 479));
      TankDir    = 2'($urandom_range(0, 3));
      collisionX = ($urandom_range(0, 9) == 0);
      collisionY = ($urandom_range(0, 9) == 0);
      step();
    end
    Reset = 1'b0; fire = 1'b0; frame_tick = 1'b0; collisionX = 1'b0; collisionY = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bullet_motion.md
BULLET_MOTION -- requirements
Module: bullet_motion

Interface
REQ-001 SHALL provide parameter SPEED, default 2, meaning 1-pixel sub-steps taken per frame.
REQ-002 SHALL provide parameter LIFETIME, default 300, meaning frames a bullet lives.
REQ-003 SHALL provide parameter MAX_BOUNCES, default 5, meaning bounces allowed before despawn.
REQ-004 SHALL provide port Clk  input  1  system clock; single clock domain.
REQ-005 SHALL provide port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port frame_tick  input  1  one-Clk pulse per video frame.
REQ-007 SHALL provide port fire  input  1  level; request to spawn a bullet.
REQ-008 SHALL provide port TankX  input  10  spawn X, pixels.
REQ-009 SHALL provide port TankY  input  10  spawn Y, pixels.
REQ-010 SHALL provide port TankDir  input  2  spawn heading: 0=up, 1=right, 2=down, 3=left.
REQ-011 SHALL provide port collisionX  input  1  combinational wall hit in X for current BulletX/BulletY, from the downstream collision stage.
REQ-012 SHALL provide port collisionY  input  1  combinational wall hit in Y, same source.
REQ-013 SHALL provide port BulletX  output  10  current bullet X, registered.
REQ-014 SHALL provide port BulletY  output  10  current bullet Y, registered.
REQ-015 SHALL provide port bullet_active  output  1  high while the FSM is not IDLE.
REQ-016 SHALL provide port despawn  output  1  one-Clk pulse when a bullet retires.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, STEP.
REQ-018 In IDLE with fire=1, SHALL on the next edge load BulletX=TankX and BulletY=TankY, set velocity (dx,dy) per TankDir (up=(0,-1), right=(+1,0), down=(0,+1), left=(-1,0)), set life=LIFETIME and bounces=0, and enter WAIT.
REQ-019 SHALL ignore fire in WAIT and STEP; one bullet at a time.
REQ-020 In WAIT with frame_tick=1, SHALL decrement life; if life becomes 0, SHALL enter IDLE and pulse despawn; otherwise SHALL load sub=SPEED and enter STEP.
REQ-021 In STEP, each Clk SHALL perform one sub-step and decrement sub; after sub-step SPEED, SHALL return to WAIT. STEP length is exactly SPEED cycles.
REQ-022 Sub-step, X axis: if dx≠0 and (collisionX=1, or BulletX=0 with dx=-1, or BulletX=639 with dx=+1), SHALL negate dx and leave BulletX unchanged; otherwise BulletX+=dx.
REQ-023 Sub-step, Y axis: same rule with collisionY, bounds 0 and 479, and dy/BulletY, evaluated in the same cycle.
REQ-024 A sub-step that reflects on either or both axes SHALL increment bounces by exactly 1.
REQ-025 If bounces would exceed MAX_BOUNCES, SHALL enter IDLE that cycle, pulse despawn, and freeze BulletX/BulletY.
REQ-026 SHALL sample collisionX/collisionY only in STEP and ignore them otherwise.
REQ-027 SHALL ignore frame_tick in STEP and IDLE; life SHALL not change then.
REQ-028 fire and frame_tick together in IDLE: SHALL accept the spawn; the tick is not counted.
REQ-029 SHALL keep BulletX/BulletY at their last values in IDLE.
REQ-030 life counter SHALL be 9 bits minimum, and bounces SHALL be wide enough for MAX_BOUNCES+1; neither counter wraps.

Reset
REQ-031 Reset SHALL take priority over all inputs.
REQ-032 Reset SHALL force state=IDLE, BulletX=0, BulletY=0, bullet_active=0, despawn=0, dx=dy=0, life=0, bounces=0 on the next edge, including mid-STEP.

Verification
REQ-033 Reset, then fire=1, TankX=100, TankY=50, TankDir=1 -> next cycle bullet_active=1, BulletX=100, BulletY=50; after one frame_tick and 2 STEP cycles, BulletX=102, BulletY=50.
REQ-034 Heading left from X=1 -> sub-steps give X=0, then X=0 (reflect, dx=+1, bounces=1), then X=1.
REQ-035 collisionX=1 held during STEP with TankDir=1 -> BulletX unchanged, dx flips, bounce counted once per reflecting sub-step; the 6th reflection with MAX_BOUNCES=5 -> despawn pulse, IDLE.
REQ-036 LIFETIME=3, no collisions -> despawn coincides with the 3rd frame_tick after spawn; BulletX reflects 2 frames of motion.
REQ-037 Reset asserted mid-STEP -> next cycle BulletX=0, BulletY=0, bullet_active=0; fire in the following cycle spawns normally.
REQ-038 fire held high while active -> no respawn; after despawn with fire still high -> respawn one cycle after IDLE is entered.
